// File: rtl/reg_file_pkg.sv
// Shared constants for the register file: zero-register index, default
// geometry and a helper that turns an address width into a register count.
package reg_file_pkg;

  localparam int REG_ZERO  = 0;
  localparam int DEFAULT_M = 32;
  localparam int DEFAULT_N = 5;
  localparam int REG_COUNT = 1 << DEFAULT_N;

  // Number of registers addressed by an n-bit address.
  function automatic int reg_count(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/mux2.sv
// Two-input M-bit multiplexer: y = sel ? b : a.
module mux2 #(
  parameter int M = 32
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         sel,
  output logic [M-1:0] y
);

  // Select between the two data inputs.
  always_comb begin
    y = a;
    if (sel) begin
      y = b;
    end else begin
      y = a;
    end
  end

endmodule

// File: rtl/reg_dec.sv
// Write-address decoder: N-bit address to a 2^N one-hot select vector.
// With en low every select line stays low, so at most one line is ever set.
module reg_dec
  import reg_file_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                    en,
  input  logic [N-1:0]            addr,
  output logic [reg_count(N)-1:0] sel
);

  localparam int W = reg_count(N);

  // One-hot decode of the address, gated by the enable.
  always_comb begin
    sel = {W{1'b0}};
    if (en) begin
      sel[addr] = 1'b1;
    end else begin
      sel = {W{1'b0}};
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: 2^N x M-bit register file, one write port, two combinational
// read ports. Register 0 is hard-wired to zero. Synchronous active-high reset
// clears every register and wins over a coincident write.
// Optional feature: define REG_FILE_BYPASS_EN to forward the write data onto a
// read port that addresses the register being written in the same cycle.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int M = DEFAULT_M,
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [N-1:0] wa,
  input  logic [M-1:0] wd,
  input  logic [N-1:0] ra1,
  input  logic [N-1:0] ra2,
  output logic [M-1:0] rd1,
  output logic [M-1:0] rd2
);

  localparam int            REGS      = reg_count(N);
  localparam logic [N-1:0]  ZERO_ADDR = N'(REG_ZERO);

  logic [M-1:0]    regs_r [0:REGS-1];
  logic [REGS-1:0] sel_s;
  logic            wr_en_s;
  logic [M-1:0]    stored1_s;
  logic [M-1:0]    stored2_s;
  logic            byp1_s;
  logic            byp2_s;

  // A write is effective only outside reset and never to the zero register,
  // so the decoder never selects register 0.
  assign wr_en_s = we & ~rst & (wa != ZERO_ADDR);

  reg_dec #(.N(N)) u_dec (
    .en   (wr_en_s),
    .addr (wa),
    .sel  (sel_s)
  );

  // Register storage: clear on reset, otherwise load the selected register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) begin
        regs_r[i] <= {M{1'b0}};
      end
    end else begin
      for (int i = 0; i < REGS; i++) begin
        if (sel_s[i]) begin
          regs_r[i] <= wd;
        end
      end
    end
  end

  // Combinational array read; address 0 always yields zero.
  always_comb begin
    stored1_s = {M{1'b0}};
    stored2_s = {M{1'b0}};
    if (ra1 != ZERO_ADDR) begin
      stored1_s = regs_r[ra1];
    end else begin
      stored1_s = {M{1'b0}};
    end
    if (ra2 != ZERO_ADDR) begin
      stored2_s = regs_r[ra2];
    end else begin
      stored2_s = {M{1'b0}};
    end
  end

`ifdef REG_FILE_BYPASS_EN
  // Forward the write data when a read port hits the register being written;
  // wr_en_s already excludes address 0, so the zero register stays zero.
  always_comb begin
    byp1_s = 1'b0;
    byp2_s = 1'b0;
    if (wr_en_s) begin
      byp1_s = (ra1 == wa);
      byp2_s = (ra2 == wa);
    end else begin
      byp1_s = 1'b0;
      byp2_s = 1'b0;
    end
  end
`else
  // No forwarding: reads return the pre-write contents during a write cycle.
  always_comb begin
    byp1_s = 1'b0;
    byp2_s = 1'b0;
  end
`endif

  mux2 #(.M(M)) u_mux1 (
    .a   (stored1_s),
    .b   (wd),
    .sel (byp1_s),
    .y   (rd1)
  );

  mux2 #(.M(M)) u_mux2 (
    .a   (stored2_s),
    .b   (wd),
    .sel (byp2_s),
    .y   (rd2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, a few hand-written
// multi-cycle sequences, then randomized traffic against an array model.
// Expected same-cycle results follow REG_FILE_BYPASS_EN as compiled.
module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int total;
  int bad;

  logic [31:0] model [0:31];

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        chk;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl [15];

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .wa  (wa),
    .wd  (wd),
    .ra1 (ra1),
    .ra2 (ra2),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic r, input logic w, input logic [4:0] a,
                              input logic [31:0] d, input logic [4:0] r1,
                              input logic [4:0] r2, input logic c,
                              input logic [31:0] x1, input logic [31:0] x2);
    vec_t v;
    v.rst = r; v.we = w; v.wa = a; v.wd = d; v.ra1 = r1; v.ra2 = r2;
    v.chk = c; v.e1 = x1; v.e2 = x2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference read: zero register, optional forwarding, else stored value.
  function automatic logic [31:0] ref_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (BYP && we && !rst && (ra == wa)) return wd;
    return model[ra];
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; we = 1'b0; wa = 5'd0; wd = 32'd0; ra1 = 5'd0; ra2 = 5'd0;

    tbl[0]  = mk(1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b0, 32'h0, 32'h0);
    tbl[1]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd7,  5'd31, 1'b1, 32'h0, 32'h0);
    tbl[2]  = mk(1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  1'b1,
                 BYP ? 32'hDEADBEEF : 32'h0, 32'h0);
    tbl[3]  = mk(1'b0, 1'b0, 5'd5,  32'h0,        5'd5,  5'd6,  1'b1, 32'hDEADBEEF, 32'h0);
    tbl[4]  = mk(1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  1'b1, 32'h0, 32'h0);
    tbl[5]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  1'b1, 32'h0, 32'hDEADBEEF);
    tbl[6]  = mk(1'b0, 1'b1, 5'd3,  32'h11,       5'd3,  5'd3,  1'b1,
                 BYP ? 32'h11 : 32'h0, BYP ? 32'h11 : 32'h0);
    tbl[7]  = mk(1'b0, 1'b1, 5'd3,  32'h22,       5'd3,  5'd5,  1'b1,
                 BYP ? 32'h22 : 32'h11, 32'hDEADBEEF);
    tbl[8]  = mk(1'b0, 1'b0, 5'd3,  32'h0,        5'd3,  5'd3,  1'b1, 32'h22, 32'h22);
    tbl[9]  = mk(1'b1, 1'b1, 5'd9,  32'h55,       5'd9,  5'd3,  1'b1, 32'h0, 32'h22);
    tbl[10] = mk(1'b0, 1'b0, 5'd9,  32'h0,        5'd9,  5'd3,  1'b1, 32'h0, 32'h0);
    tbl[11] = mk(1'b0, 1'b0, 5'd31, 32'h1,        5'd31, 5'd30, 1'b1, 32'h0, 32'h0);
    tbl[12] = mk(1'b0, 1'b0, 5'd31, 32'h1,        5'd31, 5'd30, 1'b1, 32'h0, 32'h0);
    tbl[13] = mk(1'b0, 1'b1, 5'd31, 32'h1,        5'd31, 5'd30, 1'b1,
                 BYP ? 32'h1 : 32'h0, 32'h0);
    tbl[14] = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 1'b1, 32'h1, 32'h0);

    // Directed table: drive after the falling edge, sample before the rising edge.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
      #2;
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_rd1", i), rd1, tbl[i].e1);
        check($sformatf("vec%0d_rd2", i), rd2, tbl[i].e2);
      end
    end

    // Read address change within a cycle is seen with no clock edge.
    @(negedge clk);
    rst = 1'b0; we = 1'b0; ra1 = 5'd31; ra2 = 5'd31;
    #1;
    check("addr_change_before", rd1, 32'h1);
    ra1 = 5'd30;
    #1;
    check("addr_change_after", rd1, 32'h0);
    check("same_addr_both_ports", rd2, 32'h1);

    // A reset pulse with no rising edge inside it must not clear anything.
    @(negedge clk);
    ra1 = 5'd31;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    check("rst_glitch_same_cycle", rd1, 32'h1);
    @(negedge clk);
    #1;
    check("rst_glitch_next_cycle", rd1, 32'h1);

    // Randomized phase: start from a clean reset, then mirror in the model.
    @(negedge clk);
    rst = 1'b1; we = 1'b0;
    for (int k = 0; k < 32; k++) model[k] = 32'd0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 39) == 0);
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom);
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      #2;
      check($sformatf("rnd%0d_rd1", n), rd1, ref_rd(ra1));
      check($sformatf("rnd%0d_rd2", n), rd2, ref_rd(ra2));
      if (rst) begin
        for (int k = 0; k < 32; k++) model[k] = 32'd0;
      end else if (we && wa != 5'd0) begin
        model[wa] = wd;
      end
    end

    // Final sweep of every register after the random traffic.
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    for (int k = 0; k < 32; k++) begin
      ra1 = 5'(k);
      ra2 = 5'(31 - k);
      #1;
      check($sformatf("sweep%0d_rd1", k), rd1, (k == 0) ? 32'd0 : model[k]);
      check($sformatf("sweep%0d_rd2", k), rd2, (k == 31) ? 32'd0 : model[31 - k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter M, default 32, data width in bits.
REQ-002 SHALL have parameter N, default 5, register address width; register count is 2^N.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port we, input, 1, write enable.
REQ-006 SHALL have port wa, input, N, write address, decoded to one-hot register select.
REQ-007 SHALL have port wd, input, M, write data.
REQ-008 SHALL have port ra1, input, N, read address, port 1.
REQ-009 SHALL have port ra2, input, N, read address, port 2.
REQ-010 SHALL have port rd1, output, M, read data, port 1.
REQ-011 SHALL have port rd2, output, M, read data, port 2.

Function
REQ-012 SHALL hold 2^N registers of M bits each.
REQ-013 SHALL make reads combinational: rdX = reg[raX] in the same cycle, with zero latency from address change.
REQ-014 SHALL write wd into reg[wa] at the rising clk edge when we=1 and rst=0, giving a one-cycle write latency.
REQ-015 SHALL ignore writes to address 0, so reg[0] always reads 0 regardless of we and wd.
REQ-016 SHALL ignore wa and wd when we=0; no register changes.
REQ-017 SHALL allow both read ports to address the same register; both then return the identical value.
REQ-018 SHALL make a read of wa during a write cycle follow REQ-026/REQ-027.
REQ-019 SHALL use all N address bits with no wrap or aliasing; wa=2^N-1 writes the top register only.
REQ-020 SHALL contain no other internal state; the write decoder SHALL assert at most one select line per cycle.

Reset
REQ-021 SHALL clear every register to 0 on a rising clk edge with rst=1.
REQ-022 SHALL give rst priority over we: a write coinciding with reset SHALL be lost.
REQ-023 SHALL make rd1 and rd2 read 0 for every address in the cycle after reset.
REQ-024 SHALL leave registers unchanged by rst deasserted without a clock edge; there is no asynchronous clear path.

Configuration
REQ-025 SHALL use macro REG_FILE_BYPASS_EN to control write-to-read forwarding.
REQ-026 SHALL, with REG_FILE_BYPASS_EN defined, return wd combinationally on rdX when we=1, rst=0, raX=wa and wa!=0.
REQ-027 SHALL, without REG_FILE_BYPASS_EN, return the pre-write register contents on rdX in the write cycle and the new value from the next cycle.
REQ-028 SHALL keep the forwarding result at 0 for address 0 in both builds.

Structure
REQ-029 SHALL place the shared constants in package reg_file_pkg: REG_ZERO=0, default M=32, default N=5, and register count 2^N.
REQ-030 SHALL implement the write-address decoder as sub-module reg_dec (N-bit input, 2^N one-hot output, enable input).
REQ-031 SHALL implement the bypass selection per read port with the existing mux2 (M-bit).

Verification
REQ-032 SHALL cover reset then read: rst=1 for 1 cycle, then ra1=7, ra2=31 -> rd1=0, rd2=0.
REQ-033 SHALL cover write then read: we=1, wa=5, wd=32'hDEADBEEF, one edge, then ra1=5 -> rd1=32'hDEADBEEF; ra2=6 -> rd2=0.
REQ-034 SHALL cover the zero register: we=1, wa=0, wd=32'hFFFFFFFF, one edge, then ra1=0 -> rd1=0.
REQ-035 SHALL cover same-cycle read of the write address: reg[3]=32'h11, write wa=3, wd=32'h22, ra1=3 in that cycle -> rd1=32'h22 with bypass, 32'h11 without; 32'h22 in the next cycle in both builds.
REQ-036 SHALL cover write during reset: rst=1, we=1, wa=9, wd=32'h55, one edge, then ra1=9 -> rd1=0.
REQ-037 SHALL cover disabled write and top address: we=0, wa=31, wd=32'h1 -> reg[31] stays 0; then we=1 -> reg[31]=32'h1, reg[30]=0.
